// File: rtl/tdc_edge_stats.sv
// Decodes the carry-chain TDC thermometer word and gathers edge statistics
// (min/max/sum/bubbles/no-edge) over 2^ACC_SAMPLES_LOG2 samples per request.
module tdc_edge_stats #(
  parameter int TDC_WIDTH        = 32,
  parameter int CNT_WIDTH        = 6,
  parameter int ACC_SAMPLES_LOG2 = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [TDC_WIDTH-1:0]                  tdc_data,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [CNT_WIDTH-1:0]                  res_min,
  output logic [CNT_WIDTH-1:0]                  res_max,
  output logic [CNT_WIDTH+ACC_SAMPLES_LOG2-1:0] res_sum,
  output logic [ACC_SAMPLES_LOG2:0]             res_bubbles,
  output logic [ACC_SAMPLES_LOG2:0]             res_noedge
);

  localparam int N      = 1 << ACC_SAMPLES_LOG2;
  localparam int CW     = (ACC_SAMPLES_LOG2 < 1) ? 1 : ACC_SAMPLES_LOG2;
  localparam int SW     = CNT_WIDTH + ACC_SAMPLES_LOG2;
  localparam int KW     = ACC_SAMPLES_LOG2 + 1;
  localparam logic [CNT_WIDTH-1:0] MIN_INIT  = CNT_WIDTH'(TDC_WIDTH);
  localparam logic [CW-1:0]        ACC_LAST  = CW'(N - 1);
  localparam logic [CW-1:0]        FLSH_LAST = CW'(1);
  localparam logic [KW-1:0]        ONE_K     = KW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ACCUM, S_DONE} state_t;

  state_t r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic w_clear, w_accum;

  logic [TDC_WIDTH-1:0] r_s1;
  logic [TDC_WIDTH-1:0] w_diff;
  logic [CNT_WIDTH-1:0] w_edge, r_edge;
  logic w_noedge, w_bubble, r_noedge, r_bubble;

  logic [CNT_WIDTH-1:0] r_min, r_max;
  logic [SW-1:0]        r_sum;
  logic [KW-1:0]        r_bubbles, r_noedge_cnt;

  // Bits that differ from the polarity bit; the edge is the lowest set one above bit 0.
  assign w_diff = r_s1 ^ {TDC_WIDTH{r_s1[0]}};

  always_comb begin
    w_edge   = '0;
    w_noedge = 1'b1;
    w_bubble = 1'b0;
    for (int i = 1; i < TDC_WIDTH; i++) begin
      if (!w_noedge && !w_diff[i]) begin
        w_bubble = 1'b1;
      end
      if (w_noedge && w_diff[i]) begin
        w_noedge = 1'b0;
        w_edge   = CNT_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_edge   <= '0;
      r_noedge <= 1'b0;
      r_bubble <= 1'b0;
    end else begin
      r_s1     <= tdc_data;
      r_edge   <= w_edge;
      r_noedge <= w_noedge;
      r_bubble <= w_bubble;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_clear      = 1'b0;
    w_accum      = 1'b0;
    busy         = 1'b1;
    res_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_clear      = 1'b1;
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Two cycles let the first sample travel through s1 and the decode register.
        if (r_cnt == FLSH_LAST) w_state_next = S_ACCUM;
        else                    w_cnt_next   = r_cnt + 1'b1;
      end
      S_ACCUM: begin
        w_accum = 1'b1;
        if (r_cnt == ACC_LAST) w_state_next = S_DONE;
        else                   w_cnt_next   = r_cnt + 1'b1;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_min        <= MIN_INIT;
      r_max        <= '0;
      r_sum        <= '0;
      r_bubbles    <= '0;
      r_noedge_cnt <= '0;
    end else if (w_accum) begin
      if (r_noedge) begin
        r_noedge_cnt <= r_noedge_cnt + ONE_K;
      end else begin
        if (r_edge < r_min) r_min <= r_edge;
        if (r_edge > r_max) r_max <= r_edge;
        r_sum <= r_sum + {{ACC_SAMPLES_LOG2{1'b0}}, r_edge};
        if (r_bubble) r_bubbles <= r_bubbles + ONE_K;
      end
    end
  end

  assign res_min     = r_min;
  assign res_max     = r_max;
  assign res_sum     = r_sum;
  assign res_bubbles = r_bubbles;
  assign res_noedge  = r_noedge_cnt;

endmodule
